// File: rtl/calc_pkg.sv
// Shared encodings for the calculator datapath and its control unit:
// ALU op codes, write-data select codes and register-file geometry.
package calc_pkg;

    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_ZERO = 2'b01,
        SEL_INB  = 2'b10,
        SEL_INA  = 2'b11
    } wsel_e;

endpackage

// File: rtl/calc_regfile.sv
// 4-entry register file: one write port, two enabled combinational read ports.
// Reads return the pre-write contents; a disabled read port returns zero.
module calc_regfile
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic [ADDR_W-1:0] raa,
    input  logic              rea,
    input  logic [ADDR_W-1:0] rab,
    input  logic              reb,
    output logic [WIDTH-1:0]  rd_a,
    output logic [WIDTH-1:0]  rd_b
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        // NOTE: start from the held value so every path assigns regs_d; no latch is inferred.
        regs_d = regs_q;
        if (we) begin
            regs_d[wa] = wd;
        end
    end

    // NOTE: the array is small flops, not RAM, so a full clear on reset is cheap and required.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a = rea ? regs_q[raa] : '0;
    assign rd_b = reb ? regs_q[rab] : '0;

endmodule

// File: rtl/calc_datapath.sv
// Calculator datapath: register file, inline ALU, write-back mux and display registers.
// Define CALC_FLAGS_EN to build the registered Zero/Carry flags; otherwise they are tied to 0.
module calc_datapath
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  InA,
    input  logic [WIDTH-1:0]  InB,
    input  logic [1:0]        Sel1,
    input  logic [ADDR_W-1:0] WA,
    input  logic              WE,
    input  logic [ADDR_W-1:0] RAA,
    input  logic [ADDR_W-1:0] RAB,
    input  logic              REA,
    input  logic              REB,
    input  logic [1:0]        C,
    input  logic              Sel2,
    input  logic              Done,
    output logic [WIDTH-1:0]  Out,
    output logic              Valid,
    output logic              Zero,
    output logic              Carry
);

    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;

    calc_regfile #(.WIDTH(WIDTH)) u_regfile (
        .clk  (CLK),
        .rst  (RST),
        .we   (WE),
        .wa   (WA),
        .wd   (wr_data),
        .raa  (RAA),
        .rea  (REA),
        .rab  (RAB),
        .reb  (REB),
        .rd_a (rd_a),
        .rd_b (rd_b)
    );

    always_comb begin
        alu_result = '0;
        case (C)
            OP_ADD:  alu_result = rd_a + rd_b;
            OP_SUB:  alu_result = rd_a - rd_b;
            OP_AND:  alu_result = rd_a & rd_b;
            OP_XOR:  alu_result = rd_a ^ rd_b;
            default: alu_result = '0;
        endcase
    end

    // ALU write-back uses this cycle's result, so op and store finish in one edge.
    always_comb begin
        wr_data = '0;
        case (Sel1)
            SEL_INA:  wr_data = InA;
            SEL_INB:  wr_data = InB;
            SEL_ALU:  wr_data = alu_result;
            SEL_ZERO: wr_data = '0;
            default:  wr_data = '0;
        endcase
    end

    always_comb begin
        out_d   = Sel2 ? alu_result : out_q;
        valid_d = Done;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign Out   = out_q;
    assign Valid = valid_q;

`ifdef CALC_FLAGS_EN
    logic [WIDTH:0] sum_ext;
    logic           alu_carry;
    logic           zero_q, zero_d;
    logic           carry_q, carry_d;

    // Subtract reports borrow (A < B unsigned); logic ops never carry.
    always_comb begin
        sum_ext   = {1'b0, rd_a} + {1'b0, rd_b};
        alu_carry = 1'b0;
        case (C)
            OP_ADD:  alu_carry = sum_ext[WIDTH];
            OP_SUB:  alu_carry = (rd_a < rd_b);
            default: alu_carry = 1'b0;
        endcase
        zero_d  = Sel2 ? (alu_result == '0) : zero_q;
        carry_d = Sel2 ? alu_carry : carry_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign Zero  = zero_q;
    assign Carry = carry_q;
`else
    assign Zero  = 1'b0;
    assign Carry = 1'b0;
`endif

endmodule

// File: tb/tb_calc_datapath.sv
// Self-checking bench for calc_datapath (WIDTH=4): arithmetic reference model compared
// every cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_calc_datapath;

    localparam int W   = 4;
    localparam int MOD = 1 << W;
`ifdef CALC_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_a, in_b;
    logic [1:0]   sel1, wa, raa, rab, c;
    logic         we, rea, reb, sel2, done;
    logic [W-1:0] out;
    logic         valid, zero, carry;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    int rf_m [4];
    int out_m, valid_m, zero_m, carry_m;

    always #5 clk = ~clk;

    calc_datapath #(.WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .InA(in_a), .InB(in_b), .Sel1(sel1), .WA(wa), .WE(we),
        .RAA(raa), .RAB(rab), .REA(rea), .REB(reb), .C(c), .Sel2(sel2), .Done(done),
        .Out(out), .Valid(valid), .Zero(zero), .Carry(carry)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic void alu_model(input int a, input int b, input int op,
                                      output int res, output int cy);
        case (op)
            0: begin res = (a + b) % MOD; cy = (a + b >= MOD) ? 1 : 0; end
            1: begin res = (a - b + MOD) % MOD; cy = (a < b) ? 1 : 0; end
            2: begin res = a & b; cy = 0; end
            default: begin res = a ^ b; cy = 0; end
        endcase
    endfunction

    // Advance one clock: model computes from pre-edge inputs, then all outputs are compared.
    task automatic cycle(input string tag);
        int ra, rb, res, cy, wd;
        ra = rea ? rf_m[raa] : 0;
        rb = reb ? rf_m[rab] : 0;
        alu_model(ra, rb, int'(c), res, cy);
        case (sel1)
            2'b11:   wd = int'(in_a);
            2'b10:   wd = int'(in_b);
            2'b00:   wd = res;
            default: wd = 0;
        endcase
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (rf_m[i]) rf_m[i] = 0;
            out_m = 0; valid_m = 0; zero_m = 0; carry_m = 0;
        end else begin
            if (we) rf_m[wa] = wd;
            if (sel2) begin
                out_m = res;
                if (FLAGS) begin
                    zero_m  = (res == 0) ? 1 : 0;
                    carry_m = cy;
                end
            end
            valid_m = done ? 1 : 0;
        end
        check({tag, ".out"},   int'(out),   out_m);
        check({tag, ".valid"}, int'(valid), valid_m);
        check({tag, ".zero"},  int'(zero),  zero_m);
        check({tag, ".carry"}, int'(carry), carry_m);
    endtask

    task automatic idle();
        rst = 0; we = 0; sel2 = 0; done = 0; sel1 = 2'b01; wa = 0;
        raa = 0; rab = 0; rea = 1; reb = 1; c = 0; in_a = 0; in_b = 0;
    endtask

    task automatic load(input int addr, input int val);
        idle(); we = 1; sel1 = 2'b11; wa = 2'(addr); in_a = 4'(val);
        cycle("load");
    endtask

    // Display register r through the ALU as r + 0 (port B disabled).
    task automatic show(input int r, input string tag);
        idle(); raa = 2'(r); reb = 0; c = 2'b00; sel2 = 1;
        cycle(tag);
    endtask

    initial begin
        idle();
        rst = 1;
        cycle("reset");
        check("lit.reset_out", int'(out), 0);
        check("lit.reset_valid", int'(valid), 0);

        // Load/add: R1=5, R2=3, R3=R1+R2, display with Done
        load(1, 5);
        idle(); we = 1; sel1 = 2'b10; wa = 2; in_b = 3; cycle("load_b");
        idle(); we = 1; sel1 = 2'b00; wa = 3; raa = 1; rab = 2; c = 2'b00; cycle("add_wb");
        idle(); raa = 3; reb = 0; sel2 = 1; done = 1; cycle("disp_r3");
        check("lit.add_out", int'(out), 8);
        check("lit.add_valid", int'(valid), 1);
        check("lit.add_carry", int'(carry), 0);
        idle(); cycle("valid_drop");
        check("lit.valid_one_cycle", int'(valid), 0);

        // Sub wrap: 3 - 5 written to R3 and displayed in the same cycle
        load(1, 3); load(2, 5);
        idle(); we = 1; sel1 = 2'b00; wa = 3; raa = 1; rab = 2; c = 2'b01; sel2 = 1;
        cycle("sub");
        check("lit.sub_out", int'(out), 14);
        check("lit.sub_carry", int'(carry), FLAGS ? 1 : 0);
        check("lit.sub_zero", int'(zero), 0);
        show(3, "sub_r3");
        check("lit.sub_r3", int'(out), 14);

        // Zero flag: 6 ^ 6 and 12 & 3
        load(1, 6); load(2, 6);
        idle(); raa = 1; rab = 2; c = 2'b11; sel2 = 1; cycle("xor");
        check("lit.xor_out", int'(out), 0);
        check("lit.xor_zero", int'(zero), FLAGS ? 1 : 0);
        load(1, 12); load(2, 3);
        idle(); raa = 1; rab = 2; c = 2'b10; sel2 = 1; cycle("and");
        check("lit.and_out", int'(out), 0);
        check("lit.and_zero", int'(zero), FLAGS ? 1 : 0);
        check("lit.and_carry", int'(carry), 0);

        // Add overflow: 9 + 9 wraps to 2 with carry
        load(1, 9);
        idle(); raa = 1; rab = 1; c = 2'b00; sel2 = 1; cycle("ovf");
        check("lit.ovf_out", int'(out), 2);
        check("lit.ovf_carry", int'(carry), FLAGS ? 1 : 0);

        // Read during write: old value visible this cycle, new value next cycle
        load(1, 5);
        idle(); we = 1; sel1 = 2'b11; wa = 1; in_a = 9; raa = 1; rab = 1; c = 2'b10; sel2 = 1;
        cycle("rdw");
        check("lit.rdw_old", int'(out), 5);
        idle(); raa = 1; rab = 1; c = 2'b10; sel2 = 1; cycle("rdw_next");
        check("lit.rdw_new", int'(out), 9);

        // Strobe independence
        idle(); done = 1; cycle("done_only");
        check("lit.done_only_valid", int'(valid), 1);
        check("lit.done_only_out", int'(out), 9);
        load(2, 4);
        idle(); raa = 2; reb = 0; sel2 = 1; cycle("sel2_only");
        check("lit.sel2_only_out", int'(out), 4);
        check("lit.sel2_only_valid", int'(valid), 0);

        // Reset mid-sequence overrides WE, Sel2 and Done
        load(3, 8); show(3, "pre_rst");
        check("lit.pre_rst_out", int'(out), 8);
        idle(); rst = 1; we = 1; sel1 = 2'b11; wa = 3; in_a = 7; sel2 = 1; done = 1;
        raa = 3; cycle("rst_mid");
        check("lit.rst_out", int'(out), 0);
        check("lit.rst_valid", int'(valid), 0);
        check("lit.rst_zero", int'(zero), 0);
        check("lit.rst_carry", int'(carry), 0);
        for (int r = 0; r < 4; r++) begin
            show(r, "rst_reg");
            check("lit.rst_reg_clear", int'(out), 0);
        end

        // Disabled read ports read as zero
        load(1, 7);
        idle(); raa = 1; rab = 1; rea = 0; reb = 0; c = 2'b00; sel2 = 1; cycle("re_off");
        check("lit.re_off", int'(out), 0);
        idle(); raa = 1; rab = 1; rea = 1; reb = 0; c = 2'b00; sel2 = 1; cycle("re_a_on");
        check("lit.re_a_on", int'(out), 7);

        // Short pseudo-random run against the model
        for (int i = 0; i < 60; i++) begin
            rst  = ($urandom_range(0, 29) == 0);
            in_a = 4'($urandom_range(0, 15)); in_b = 4'($urandom_range(0, 15));
            sel1 = 2'($urandom_range(0, 3));  wa   = 2'($urandom_range(0, 3));
            we   = 1'($urandom_range(0, 1));  raa  = 2'($urandom_range(0, 3));
            rab  = 2'($urandom_range(0, 3));  rea  = ($urandom_range(0, 3) != 0);
            reb  = ($urandom_range(0, 3) != 0); c  = 2'($urandom_range(0, 3));
            sel2 = 1'($urandom_range(0, 1));  done = 1'($urandom_range(0, 1));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_datapath.md
CALC_DATAPATH -- requirements
Module: calc_datapath

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits; legal range 2..16.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 InA  input  WIDTH  external operand A.
REQ-005 InB  input  WIDTH  external operand B.
REQ-006 Sel1  input  2  write-data select: 11 InA, 10 InB, 00 ALU result, 01 constant zero.
REQ-007 WA  input  2  register-file write address.
REQ-008 WE  input  1  register-file write enable.
REQ-009 RAA / RAB  input  2 each  read addresses for ALU ports A and B.
REQ-010 REA / REB  input  1 each  read enables; a disabled port reads as zero.
REQ-011 C  input  2  ALU op: 00 add, 01 sub (A-B), 10 and, 11 xor.
REQ-012 Sel2  input  1  1 = capture the ALU result into Out.
REQ-013 Done  input  1  control-unit completion strobe.
REQ-014 Out  output  WIDTH  registered display value.
REQ-015 Valid  output  1  registered completion pulse aligned with the Out update.
REQ-016 Zero, Carry  output  1 each  registered result flags (see Configuration).

Function
REQ-017 Register file: 4 x WIDTH entries; when WE=1, entry WA is written with the Sel1-selected value at the clock edge.
REQ-018 Read ports: combinational; data is RF[RAA] when REA=1, else 0; port B behaves the same with RAB/REB.
REQ-019 Read during write to the same address: returns the pre-write (old) value; the new value is visible the next cycle.
REQ-020 ALU: combinational on the port A/B read data; result is truncated to WIDTH bits; add/sub wrap modulo 2^WIDTH.
REQ-021 ALU carry: add produces the carry-out; sub produces the borrow (1 when A<B unsigned); and/xor produce 0.
REQ-022 Sel1=00 writes the current-cycle ALU result, so op and write-back complete in one cycle.
REQ-023 Out: loads the ALU result on the edge where Sel2=1; otherwise it holds.
REQ-024 Valid: equals Done registered one cycle later; it is high for exactly one cycle per Done cycle.
REQ-025 Sel2=1 with Done=0: Out updates and Valid stays 0.
REQ-026 Done=1 with Sel2=0: Valid pulses and Out holds its previous value.
REQ-027 WE together with Sel2 in the same cycle: both actions occur; Out uses the pre-write read data.
REQ-028 Every control-input combination is legal; there are no error states.

Reset
REQ-029 When RST=1 at an edge, all four registers, Out, Valid, Zero and Carry are cleared to 0; RST overrides WE, Sel2 and Done.
REQ-030 Reset asserted mid-sequence discards any partial result; the next load starts from a cleared register file.

Configuration
REQ-031 Macro CALC_FLAGS_EN defined: Zero and Carry load on the same edge as Out (Sel2=1). Zero=(result==0); Carry follows REQ-021.
REQ-032 Macro CALC_FLAGS_EN undefined: the Zero and Carry ports remain present and are driven constant 0, and no flag logic is built.

Structure
REQ-033 Shared package calc_pkg holds the ALU op codes, the Sel1 codes, the register count (4) and the address width (2); the control unit and this block both use it.
REQ-034 Sub-module calc_regfile implements the register file (write port, two enabled read ports, synchronous reset); the ALU, Sel1 mux and output registers are inline.

Verification (WIDTH=4)
REQ-035 Load/add: Sel1=11, WA=01, InA=5; then Sel1=10, WA=10, InB=3; then RAA=01, RAB=10, C=00, Sel1=00, WA=11; then display R3 with Sel2=1, Done=1 -> Out=8, Valid=1 on the following cycle, Carry=0.
REQ-036 Sub wrap: R1=3, R2=5, C=01 written to R3 and displayed -> Out=14, Carry=1, Zero=0 with the macro defined; Carry=0 and Zero=0 without it.
REQ-037 Zero flag: R1=R2=6, C=11 (xor), displayed -> Out=0, Zero=1; and 12 & 3 -> Out=0, Zero=1, Carry=0.
REQ-038 Read during write: WE=1, WA=01, InA=9, RAA=01, REA=1, Sel2=1 with old R1=5 and C=10, RAB=01, REB=1 -> Out=5; the next-cycle read gives 9.
REQ-039 Reset: RST=1 after R3=8 and Out=8 -> next cycle all registers, Out, Valid and flags are 0; REA=0 or REB=0 reads give 0.
REQ-040 Strobe independence: Done=1 with Sel2=0 -> Valid pulses one cycle later and Out is unchanged; Sel2=1 with Done=0 -> Out updates and Valid stays 0.
